// File: rtl/mem_stream_ctrl.sv
// Burst streaming controller for a sequential-address memory: loads a burst of
// words from the input stream, rewinds the pointer, and streams them back out.
module mem_stream_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic [1:0]        rd_wait,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              mem_rst_n,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_multi_cycle_mode,
  output logic [1:0]        mem_cycle_count
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] CLEAR  = 4'd1;
  localparam logic [3:0] LOAD   = 4'd2;
  localparam logic [3:0] WDRAIN = 4'd3;
  localparam logic [3:0] REWIND = 4'd4;
  localparam logic [3:0] RISSUE = 4'd5;
  localparam logic [3:0] RCAPT  = 4'd6;
  localparam logic [3:0] RDRAIN = 4'd7;
  localparam logic [3:0] FINISH = 4'd8;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  logic [3:0]       state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       wcnt;
  logic [LEN_W-1:0] len_sat;
  logic             out_free;

  // Both streams: a word moves on a clock edge where valid && ready; a source
  // holds valid and data steady until that edge, and ready never depends on valid.
  assign out_free = !m_valid || m_ready;
  assign len_sat  = (length > DEPTH_L) ? DEPTH_L : length;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      len                  <= '0;
      cnt                  <= '0;
      wcnt                 <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      s_ready              <= 1'b0;
      m_valid              <= 1'b0;
      m_data               <= '0;
      mem_rst_n            <= 1'b0;
      mem_wr_en            <= 1'b0;
      mem_rd_en            <= 1'b0;
      mem_data_in          <= '0;
      mem_multi_cycle_mode <= 1'b0;
      mem_cycle_count      <= '0;
    end else begin
      done      <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_rst_n <= 1'b1;
      if (m_valid && m_ready) m_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            len                  <= len_sat;
            cnt                  <= '0;
            mem_cycle_count      <= rd_wait;
            mem_multi_cycle_mode <= (rd_wait != 2'd0);
            busy                 <= 1'b1;
            if (len_sat == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              mem_rst_n <= 1'b0;
              state     <= CLEAR;
            end
          end
        end
        CLEAR: begin
          s_ready <= 1'b1;
          state   <= LOAD;
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            mem_wr_en   <= 1'b1;
            mem_data_in <= s_data;
            cnt         <= cnt + ONE_L;
            if (cnt + ONE_L == len) begin
              s_ready <= 1'b0;
              state   <= WDRAIN;
            end
          end
        end
        WDRAIN: begin
          mem_rst_n <= 1'b0;
          cnt       <= '0;
          state     <= REWIND;
        end
        REWIND: state <= RISSUE;
        RISSUE: begin
          // The read window opens only once the previous word has left the output register.
          if (mem_rd_en) begin
            if (wcnt == mem_cycle_count) begin
              mem_rd_en <= 1'b0;
              state     <= RCAPT;
            end else begin
              wcnt <= wcnt + 2'd1;
            end
          end else if (out_free) begin
            mem_rd_en <= 1'b1;
            wcnt      <= '0;
          end
        end
        RCAPT: begin
          m_data  <= mem_data_out;
          m_valid <= 1'b1;
          cnt     <= cnt + ONE_L;
          state   <= (cnt + ONE_L < len) ? RISSUE : RDRAIN;
        end
        RDRAIN: begin
          if (m_valid && m_ready) begin
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          s_ready   <= 1'b0;
          mem_rd_en <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stream_ctrl.md
Name: mem_stream_ctrl

Overview:
- Initiator/controller for the sequential-address on-chip memory (1K x 16, single internal address pointer shared by writes and reads, rewound only by its active-low reset).
- Accepts a burst of words on a valid/ready input stream and writes them into memory from address 0.
- Rewinds the pointer, reads the words back in order with the memory's multi-cycle read timing, and presents them on a valid/ready output stream.
- Sits between the upstream producer, the memory instance, and the downstream consumer.

Parameters:
- DATA_W, 16, word width; must match memory width.
- DEPTH, 1024, memory depth in words.
- LEN_W, 11, width of length input; holds 0..DEPTH.

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
- length  input  LEN_W  number of words; latched on accepted start.
- rd_wait  input  2  extra read cycles per word; latched on accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of transfer.
- s_valid  input  1  input-stream word valid.
- s_ready  output  1  controller accepts input word.
- s_data  input  DATA_W  input-stream word.
- m_valid  output  1  output-stream word valid.
- m_ready  input  1  consumer accepts output word.
- m_data  output  DATA_W  output-stream word.
- mem_rst_n  output  1  drives memory reset_n; pulse low to rewind pointer.
- mem_wr_en  output  1  memory write enable.
- mem_rd_en  output  1  memory read enable.
- mem_data_in  output  DATA_W  memory write data.
- mem_data_out  input  DATA_W  memory read data.
- mem_multi_cycle_mode  output  1  equals (latched rd_wait != 0).
- mem_cycle_count  output  2  equals latched rd_wait.

Behaviour:
- Reset values: busy=0, done=0, s_ready=0, m_valid=0, m_data=0, mem_wr_en=0, mem_rd_en=0, mem_data_in=0, mem_rst_n=0, mem_multi_cycle_mode=0, mem_cycle_count=0. State goes to IDLE.
- mem_rst_n rises to 1 on the first cycle after reset deasserts.
- All outputs are registered. mem_wr_en and mem_rd_en are never high in the same cycle.

States:
- IDLE: wait for start.
  - On start: latch length, saturated to DEPTH if greater. Latch rd_wait as W.
  - If latched length = 0: go to FINISH with no memory access.
  - Otherwise go to CLEAR.
- CLEAR: mem_rst_n=0 for exactly 1 cycle, then go to LOAD.
- LOAD: s_ready=1 while accepted count < length.
  - Each s_valid&&s_ready registers mem_wr_en=1 and mem_data_in=s_data on the next cycle. Otherwise mem_wr_en=0.
  - On the cycle the final word is accepted, s_ready drops, effective next cycle. Go to WDRAIN.
- WDRAIN: 1 cycle so the final write lands, then go to REWIND.
- REWIND: mem_rst_n=0 for 1 cycle, then go to RISSUE.
- RISSUE: starts only when the output register is free (m_valid=0, or m_valid&&m_ready this cycle).
  - Holds mem_rd_en=1 for exactly W+1 consecutive cycles, then go to RCAPT.
- RCAPT: mem_rd_en=0. m_data<=mem_data_out and m_valid<=1, visible the next cycle.
  - Read count increments.
  - If read count < length, go to RISSUE. Otherwise go to RDRAIN.
- RDRAIN: wait for the final m_valid&&m_ready, then go to FINISH.
- FINISH: done=1 for 1 cycle, then go to IDLE.

Output stream:
- m_valid stays high until m_ready; m_data is stable while m_valid&&!m_ready.
- No read is issued while an unconsumed word is held.

Timing and boundaries:
- Latency: the last cycle of the rd_en window is t; m_valid rises at t+2. Peak output rate is one word per W+3 cycles.
- Words are returned in write order. Word i is read from address i.
- length = DEPTH: the pointer wraps to 0 after the final write. REWIND still runs (harmless).
- start while busy is ignored. s_valid outside LOAD is ignored (s_ready=0).
- reset at any point: immediate return to reset values and IDLE. Memory contents are not valid for reuse; the next transfer rewrites them.

Test Plan:
- length=4, rd_wait=0, inputs 0x1111,0x2222,0x3333,0x4444, m_ready=1 -> output same four words in order; mem_rst_n low exactly 2 single cycles (CLEAR, REWIND); 4 mem_wr_en pulses; 4 single-cycle mem_rd_en pulses; done pulses once after the 4th output handshake.
- length=3, rd_wait=2 -> mem_multi_cycle_mode=1, mem_cycle_count=2; each word has mem_rd_en high 3 consecutive cycles; m_valid rises 2 cycles after each window ends; data correct.
- length=2, m_ready held low 10 cycles after first m_valid -> m_data stable at word 0; no mem_rd_en during stall; word 1 follows after m_ready=1.
- length=0, start=1 -> busy high 1 cycle (FINISH); done pulse 1 cycle after start; no mem_wr_en, mem_rd_en or mem_rst_n activity.
- length=2000 (saturates to 1024), inputs 0..1023, s_valid toggled randomly -> exactly 1024 words accepted, s_ready then drops; outputs 0..1023 in order.
- reset asserted mid-LOAD after 5 of 8 words -> all outputs at reset values the next cycle; a new start with length=2 then completes correctly with fresh data.
